tick_scheduler: RTL and testbench

- Sequences the system clock-enable for the TessiaX core.
- Replaces free-running slow-clock generation with a controlled tick source that has three modes: HALT, RUN at a programmable divide ratio, and STEP (one tick per button press).
- Sits between the board clock and the core's enable input; the divisor is loaded at runtime through a load/ack handshake.
- Also drives a 50%-style slow_clk for LED/debug observation.

---
 rtl/tick_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_tick_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// ============================================================================
// Module   : tick_scheduler
// Purpose  : Clock-enable sequencer for the TessiaX core. Issues one-cycle
//            tick pulses in three modes: HALT (none), RUN (every eff_div
//            cycles, divisor loadable at runtime with a load/ack handshake)
//            and STEP (one tick per step button press). Also drives a
//            slow_clk that toggles on every tick and a wrapping tick counter.
// Options  : `define TICK_SCHED_DEBOUNCE_EN adds a DEB_CYCLES stable-time
//            debouncer on the synchronized step button.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_scheduler #(
  parameter int CNT_W       = 25,
  parameter int DEFAULT_DIV = 250000,
  parameter int TCNT_W      = 16,
  parameter int DEB_CYCLES  = 500000
) (
  input  logic              C_50Mhz,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              step_btn,
  input  logic [CNT_W-1:0]  div_val,
  input  logic              div_load,
  output logic              div_ack,
  output logic              tick,
  output logic              slow_clk,
  output logic [1:0]        state,
  output logic [TCNT_W-1:0] tick_count
);

  // State encoding matches the mode input encoding.
  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;

  logic [1:0]        state_q, state_d;
  logic              run_en, step_en;
  logic [CNT_W-1:0]  counter_q, counter_d;
  logic [CNT_W-1:0]  div_reg_q, div_reg_d;
  logic [CNT_W-1:0]  eff_div_m1;
  logic              wrap;
  logic              state_chg;
  logic              sync1_q, sync2_q;
  logic              btn_lvl;
  logic              btn_prev_q;
  logic              btn_rise;
  logic              tick_q, tick_d;
  logic              div_ack_q;
  logic              slow_clk_q;
  logic [TCNT_W-1:0] tick_count_q;

  // State register.
  always_ff @(posedge C_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state is simply the decoded mode; the reserved code parks in HALT.
  always_comb begin
    state_d = S_HALT;
    case (mode)
      2'b01:   state_d = S_RUN;
      2'b10:   state_d = S_STEP;
      default: state_d = S_HALT;
    endcase
  end

  // State decode into the enables used by the datapath.
  always_comb begin
    run_en  = 1'b0;
    step_en = 1'b0;
    case (state_q)
      S_RUN:   run_en  = 1'b1;
      S_STEP:  step_en = 1'b1;
      default: ;
    endcase
  end

  // A zero divisor behaves as one, giving a tick every cycle.
  assign eff_div_m1 = (div_reg_q == '0) ? '0 : (div_reg_q - 1'b1);
  assign wrap       = run_en && (counter_q == eff_div_m1);
  assign state_chg  = (state_d != state_q);

  // Period counter: restarts on load, on any state change, at wrap, and is
  // parked at zero outside RUN so a partial period never carries over.
  always_comb begin
    counter_d = counter_q + 1'b1;
    if (div_load || state_chg || !run_en || wrap) begin
      counter_d = '0;
    end
    div_reg_d = div_load ? div_val : div_reg_q;
  end

  // Period counter and divisor register.
  always_ff @(posedge C_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
      div_reg_q <= CNT_W'(DEFAULT_DIV);
    end else begin
      counter_q <= counter_d;
      div_reg_q <= div_reg_d;
    end
  end

  // Two-flop synchronizer for the asynchronous step button; runs in all states.
  always_ff @(posedge C_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= step_btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef TICK_SCHED_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic             deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // Debounced level follows the synchronized button only after it has held
  // the new level for DEB_CYCLES consecutive clocks.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Debouncer registers.
  always_ff @(posedge C_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign btn_lvl = deb_q;
`else
  // Stable-time parameter only matters when the debouncer is built in.
  logic [31:0] unused_deb_cycles;
  assign unused_deb_cycles = 32'(DEB_CYCLES);

  assign btn_lvl = sync2_q;
`endif

  // Edge-detect history; tracks the button level in every state so that
  // entering STEP with the button already held yields no tick.
  always_ff @(posedge C_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= 1'b0;
    end else begin
      btn_prev_q <= btn_lvl;
    end
  end

  assign btn_rise = btn_lvl & ~btn_prev_q;
  assign tick_d   = wrap | (step_en & btn_rise);

  // Tick, ack, slow clock and tick counter all update together with tick.
  always_ff @(posedge C_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      tick_q       <= 1'b0;
      div_ack_q    <= 1'b0;
      slow_clk_q   <= 1'b1;
      tick_count_q <= '0;
    end else begin
      tick_q       <= tick_d;
      div_ack_q    <= div_load;
      slow_clk_q   <= slow_clk_q ^ tick_d;
      tick_count_q <= tick_count_q + TCNT_W'(tick_d);
    end
  end

  assign tick       = tick_q;
  assign div_ack    = div_ack_q;
  assign slow_clk   = slow_clk_q;
  assign state      = state_q;
  assign tick_count = tick_count_q;

endmodule

`default_nettype wire

// File: tb/tb_tick_scheduler.sv
// ============================================================================
// Module   : tb_tick_scheduler
// Purpose  : Directed self-checking bench for tick_scheduler. The default
//            divisor and tick counter width are scaled down so the run is
//            short; expected tick positions are computed by hand per test.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_scheduler;

  localparam int CNT_W       = 25;
  localparam int DEFAULT_DIV = 12;
  localparam int TCNT_W      = 8;
  localparam int DEB_CYCLES  = 8;
`ifdef TICK_SCHED_DEBOUNCE_EN
  localparam int LAT = DEB_CYCLES + 3;
`else
  localparam int LAT = 3;
`endif

  logic              clk;
  logic              rst_n;
  logic [1:0]        mode;
  logic              step_btn;
  logic [CNT_W-1:0]  div_val;
  logic              div_load;
  logic              div_ack;
  logic              tick;
  logic              slow_clk;
  logic [1:0]        state;
  logic [TCNT_W-1:0] tick_count;

  int                vectors;
  int                miscompares;
  logic [TCNT_W-1:0] exp_tc;
  logic              exp_slow;
  logic              et;

  tick_scheduler #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV),
    .TCNT_W     (TCNT_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .C_50Mhz   (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .step_btn  (step_btn),
    .div_val   (div_val),
    .div_load  (div_load),
    .div_ack   (div_ack),
    .tick      (tick),
    .slow_clk  (slow_clk),
    .state     (state),
    .tick_count(tick_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Compare tick against et; on expected ticks also check the slow clock and
  // tick counter against the running model.
  task automatic tick_cmp(input string name, input int idx);
    vectors++;
    if (tick !== et) begin
      miscompares++;
      $display("FAIL %s tick idx=%0d got=%b exp=%b", name, idx, tick, et);
    end
    if (et) begin
      exp_tc   = exp_tc + 1'b1;
      exp_slow = ~exp_slow;
      vectors++;
      if (tick_count !== exp_tc) begin
        miscompares++;
        $display("FAIL %s tick_count idx=%0d got=%0h exp=%0h", name, idx, tick_count, exp_tc);
      end
      vectors++;
      if (slow_clk !== exp_slow) begin
        miscompares++;
        $display("FAIL %s slow_clk idx=%0d got=%b exp=%b", name, idx, slow_clk, exp_slow);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b00; step_btn = 1'b0; div_val = '0; div_load = 1'b0;
    exp_tc = '0; exp_slow = 1'b1;
    repeat (3) cyc();
    vectors++;
    if ({state, tick, div_ack, slow_clk} !== {2'b00, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b%b%b%b exp=00001", state, tick, div_ack, slow_clk);
    end
    vectors++;
    if (tick_count !== '0) begin
      miscompares++;
      $display("FAIL reset_tick_count got=%0h exp=0", tick_count);
    end
    rst_n = 1'b1;
    cyc();
    vectors++;
    if (state !== 2'b00 || tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got state=%b tick=%b exp state=00 tick=0", state, tick);
    end
  endtask

  // Default divisor in RUN: first tick DEFAULT_DIV cycles after RUN shows.
  task automatic test_default_run();
    mode = 2'b01;
    for (int i = 1; i <= 3 * DEFAULT_DIV + 1; i++) begin
      cyc();
      if (i == 1) begin
        vectors++;
        if (state !== 2'b01) begin
          miscompares++;
          $display("FAIL default_run state got=%b exp=01", state);
        end
      end
      et = (i > 1) && (((i - 1) % DEFAULT_DIV) == 0);
      tick_cmp("default_run", i);
    end
  endtask

  // Load 4 mid-RUN, then a load landing on a wrap cycle.
  task automatic test_div_load();
    div_val = 4; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    vectors++;
    if (div_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL div_load ack got=%b exp=1", div_ack);
    end
    et = 1'b0;
    tick_cmp("div_load_edge", 0);
    for (int j = 1; j <= 15; j++) begin
      cyc();
      if (j == 1) begin
        vectors++;
        if (div_ack !== 1'b0) begin
          miscompares++;
          $display("FAIL div_load ack_drop got=%b exp=0", div_ack);
        end
      end
      et = ((j % 4) == 0);
      tick_cmp("div4", j);
    end
    // Counter is now 3: this load coincides with the old-period wrap.
    div_val = 6; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    vectors++;
    if (div_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL load_wrap ack got=%b exp=1", div_ack);
    end
    et = 1'b1;
    tick_cmp("load_wrap_old_tick", 0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      et = ((k % 6) == 0);
      tick_cmp("div6", k);
    end
  endtask

  // Level-held load acks every cycle; divisor 0 ticks every cycle and wraps count.
  task automatic test_back_to_back();
    div_val = 0; div_load = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      vectors++;
      if (div_ack !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ack idx=%0d got=%b exp=1", i, div_ack);
      end
      et = (i >= 2);
      tick_cmp("b2b_load", i);
    end
    div_load = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      cyc();
      et = 1'b1;
      tick_cmp("div0", i);
    end
  endtask

  // RUN at 10, HALT mid-period (also reserved mode), then resume.
  task automatic test_halt_resume();
    div_val = 10; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    et = 1'b1;
    tick_cmp("div10_load", 0);
    for (int i = 1; i <= 7; i++) begin
      cyc();
      et = 1'b0;
      tick_cmp("div10_pre", i);
    end
    mode = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i == 4) mode = 2'b11;
      vectors++;
      if (state !== 2'b00) begin
        miscompares++;
        $display("FAIL halt_state idx=%0d got=%b exp=00", i, state);
      end
      et = 1'b0;
      tick_cmp("halt", i);
    end
    mode = 2'b01;
    cyc();
    vectors++;
    if (state !== 2'b01) begin
      miscompares++;
      $display("FAIL resume_state got=%b exp=01", state);
    end
    et = 1'b0;
    tick_cmp("resume_entry", 0);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      et = (k == 10);
      tick_cmp("resume", k);
    end
  endtask

  // STEP: three short presses, one long hold, and a press held across entry.
  task automatic test_step();
    mode = 2'b10;
    cyc();
    vectors++;
    if (state !== 2'b10) begin
      miscompares++;
      $display("FAIL step_state got=%b exp=10", state);
    end
    et = 1'b0;
    tick_cmp("step_entry", 0);
    for (int p = 0; p < 3; p++) begin
      step_btn = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        cyc();
        if (c == 10) step_btn = 1'b0;
        et = (c == LAT);
        tick_cmp("step_press", p * 100 + c);
      end
    end
    step_btn = 1'b1;
    for (int c = 1; c <= 130; c++) begin
      cyc();
      if (c == 100) step_btn = 1'b0;
      et = (c == LAT);
      tick_cmp("step_hold", c);
    end
    mode = 2'b00;
    cyc();
    step_btn = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if (c == 15) mode = 2'b10;
      et = 1'b0;
      tick_cmp("step_held_entry", c);
    end
    step_btn = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      et = 1'b0;
      tick_cmp("step_release", c);
    end
  endtask

  // Asynchronous reset mid-period restores outputs and the default divisor.
  task automatic test_reset_mid();
    div_val = 4; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    vectors++;
    if (div_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL step_load_ack got=%b exp=1", div_ack);
    end
    mode = 2'b01;
    cyc();
    et = 1'b0;
    tick_cmp("rm_entry", 0);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      et = (i == 4);
      tick_cmp("rm_run", i);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({state, tick, div_ack, slow_clk} !== {2'b00, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL async_reset got=%b%b%b%b exp=00001", state, tick, div_ack, slow_clk);
    end
    vectors++;
    if (tick_count !== '0) begin
      miscompares++;
      $display("FAIL async_reset_count got=%0h exp=0", tick_count);
    end
    exp_tc = '0; exp_slow = 1'b1;
    cyc();
    rst_n = 1'b1;
    for (int i = 1; i <= 2 * DEFAULT_DIV + 1; i++) begin
      cyc();
      et = (i > 1) && (((i - 1) % DEFAULT_DIV) == 0);
      tick_cmp("post_reset_div", i);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    et = 1'b0;
    test_reset();
    test_default_run();
    test_div_load();
    test_back_to_back();
    test_halt_resume();
    test_step();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
